// File: rtl/riscv_controller_pkg.sv
// Shared opcodes, control encodings and the decoded-strobe bundle for the RV32I controller.
package riscv_controller_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned IMM_W   = 2;
    localparam int unsigned RES_W   = 2;

    // Supported opcodes
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    // ALUControl encodings
    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

    // Internal ALUOp encodings between the two decoders
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNC = 2'b10;

    // ImmSrc encodings
    localparam logic [IMM_W-1:0] IMM_I = 2'b00;
    localparam logic [IMM_W-1:0] IMM_S = 2'b01;
    localparam logic [IMM_W-1:0] IMM_B = 2'b10;
    localparam logic [IMM_W-1:0] IMM_J = 2'b11;

    // ResultSrc encodings
    localparam logic [RES_W-1:0] RES_ALU = 2'b00;
    localparam logic [RES_W-1:0] RES_MEM = 2'b01;
    localparam logic [RES_W-1:0] RES_PC4 = 2'b10;

    // Strobes produced by the main decoder
    typedef struct packed {
        logic               reg_write;
        logic [IMM_W-1:0]   imm_src;
        logic               alu_src;
        logic               mem_write;
        logic [RES_W-1:0]   result_src;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
        logic               jump;
    } ctrl_t;

    // True for the six opcodes this controller implements
    function automatic logic is_supported_op(input logic [OP_W-1:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_IALU, OP_JAL: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_controller_if.sv
// Datapath <-> controller bundle: instruction fields and flag in, control strobes out.
interface riscv_controller_if;
    import riscv_controller_pkg::*;

    logic [OP_W-1:0]   op;
    logic [F3_W-1:0]   funct3;
    logic              funct7b5;
    logic              Zero;
    logic [RES_W-1:0]  ResultSrc;
    logic              MemWrite;
    logic              PCSrc;
    logic              ALUSrc;
    logic              RegWrite;
    logic              Jump;
    logic [IMM_W-1:0]  ImmSrc;
    logic [ALUC_W-1:0] ALUControl;
    logic              illegal_op;

    // Datapath side
    modport master (
        output op, funct3, funct7b5, Zero,
        input  ResultSrc, MemWrite, PCSrc, ALUSrc, RegWrite, Jump, ImmSrc, ALUControl, illegal_op
    );

    // Controller side
    modport slave (
        input  op, funct3, funct7b5, Zero,
        output ResultSrc, MemWrite, PCSrc, ALUSrc, RegWrite, Jump, ImmSrc, ALUControl, illegal_op
    );
endinterface

// File: rtl/riscv_controller_alu_decoder.sv
// ALUOp and instruction function bits to ALUControl.
module riscv_controller_alu_decoder
    import riscv_controller_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [F3_W-1:0]    funct3,
    input  logic               op5,
    input  logic               funct7b5,
    output logic [ALUC_W-1:0]  alu_control
);

    // Subtract only for R-type with funct7b5; addi with bit 30 set still adds
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:  alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:    alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_controller_main_decoder.sv
// Opcode to datapath strobes plus ALUOp; unsupported opcodes give all-zero strobes.
module riscv_controller_main_decoder
    import riscv_controller_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl
);

    // Per-opcode strobe table, zeros by default so nothing writes on an unknown op
    always_comb begin
        ctrl = '0;
        case (op)
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_STORE: begin
                ctrl.imm_src    = IMM_S;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_RTYPE: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALU;
                ctrl.alu_op     = ALUOP_FUNC;
            end
            OP_BRANCH: begin
                ctrl.imm_src    = IMM_B;
                ctrl.branch     = 1'b1;
                ctrl.alu_op     = ALUOP_SUB;
            end
            OP_IALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_ALU;
                ctrl.alu_op     = ALUOP_FUNC;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_J;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/riscv_controller.sv
// Single-cycle RV32I control unit: combinational strobes plus a sticky illegal-opcode flag.
module riscv_controller
    import riscv_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    riscv_controller_if.slave bus
);

    ctrl_t             ctrl;
    logic [ALUC_W-1:0] alu_control;
    logic              illegal_q;

    riscv_controller_main_decoder u_main_decoder (
        .op   (bus.op),
        .ctrl (ctrl)
    );

    riscv_controller_alu_decoder u_alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct3      (bus.funct3),
        .op5         (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (alu_control)
    );

    assign bus.ResultSrc  = ctrl.result_src;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.ALUSrc     = ctrl.alu_src;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.Jump       = ctrl.jump;
    assign bus.ImmSrc     = ctrl.imm_src;
    assign bus.ALUControl = alu_control;
    assign bus.PCSrc      = (ctrl.branch & bus.Zero) | ctrl.jump;
    assign bus.illegal_op = illegal_q;

    // Sticky record of any unsupported opcode seen since reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_q | ~is_supported_op(bus.op);
        end
    end

endmodule

// File: tb/tb_riscv_controller.sv
// Directed bench for riscv_controller with a queue of expected strobe vectors.
module tb_riscv_controller;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    riscv_controller_if bus ();

    riscv_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector {ResultSrc, MemWrite, PCSrc, ALUSrc, RegWrite, Jump, ImmSrc, ALUControl}
    function automatic logic [12:0] pk(input logic [1:0] rs, input logic mw, input logic pc,
                                       input logic as, input logic rw, input logic j,
                                       input logic [1:0] is, input logic [2:0] ac);
        return {rs, mw, pc, as, rw, j, is, ac};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.ResultSrc, bus.MemWrite, bus.PCSrc, bus.ALUSrc, bus.RegWrite,
                bus.Jump, bus.ImmSrc, bus.ALUControl};
    endfunction

    // Drive one instruction at the falling edge, queue its expectation, compare after settling
    task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic z, input logic [12:0] exp_v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
        e.tag = tag;
        e.v   = exp_v;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        checks++;
        assert (observed() === got.v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", got.tag, observed(), got.v);
        end
    endtask

    task automatic check_flag(input string tag, input logic exp_v);
        checks++;
        assert (bus.illegal_op === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, bus.illegal_op, exp_v);
        end
    endtask

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.op       = 7'b0000011;
        bus.funct3   = 3'b000;
        bus.funct7b5 = 1'b0;
        bus.Zero     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_flag("reset_flag", 1'b0);
        @(negedge clk);
        reset = 1'b0;

        step("lw_f3_000",  7'b0000011, 3'b000, 1'b0, 1'b0, pk(2'b01, 0, 0, 1, 1, 0, 2'b00, 3'b000));
        step("lw_f3_100",  7'b0000011, 3'b100, 1'b0, 1'b0, pk(2'b01, 0, 0, 1, 1, 0, 2'b00, 3'b000));
        step("addi_f7_0",  7'b0010011, 3'b000, 1'b0, 1'b0, pk(2'b00, 0, 0, 1, 1, 0, 2'b00, 3'b000));
        step("addi_f7_1",  7'b0010011, 3'b000, 1'b1, 1'b0, pk(2'b00, 0, 0, 1, 1, 0, 2'b00, 3'b000));
        step("slti",       7'b0010011, 3'b010, 1'b0, 1'b1, pk(2'b00, 0, 0, 1, 1, 0, 2'b00, 3'b101));
        step("beq_z1",     7'b1100011, 3'b000, 1'b0, 1'b1, pk(2'b00, 0, 1, 0, 0, 0, 2'b10, 3'b001));
        step("beq_z0",     7'b1100011, 3'b000, 1'b0, 1'b0, pk(2'b00, 0, 0, 0, 0, 0, 2'b10, 3'b001));
        step("jal",        7'b1101111, 3'b000, 1'b0, 1'b0, pk(2'b10, 0, 1, 0, 1, 1, 2'b11, 3'b000));
        step("sw",         7'b0100011, 3'b010, 1'b1, 1'b1, pk(2'b00, 1, 0, 1, 0, 0, 2'b01, 3'b000));
        step("r_add_z1",   7'b0110011, 3'b000, 1'b0, 1'b1, pk(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b000));
        step("r_add_z0",   7'b0110011, 3'b000, 1'b0, 1'b0, pk(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b000));
        step("r_sub",      7'b0110011, 3'b000, 1'b1, 1'b0, pk(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b001));
        step("r_slt",      7'b0110011, 3'b010, 1'b0, 1'b0, pk(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b101));
        step("r_or",       7'b0110011, 3'b110, 1'b0, 1'b0, pk(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b011));
        step("r_and",      7'b0110011, 3'b111, 1'b0, 1'b0, pk(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b010));
        step("r_f3_001",   7'b0110011, 3'b001, 1'b1, 1'b0, pk(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b000));
        #1;
        check_flag("flag_after_legal", 1'b0);

        // Unsupported opcode: strobes zero now, flag set only after the next rising edge
        step("illegal_7f", 7'b1111111, 3'b111, 1'b1, 1'b1, pk(2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000));
        check_flag("flag_before_edge", 1'b0);
        @(posedge clk);
        #1;
        check_flag("flag_after_edge", 1'b1);
        step("jalr_unsup", 7'b1100111, 3'b000, 1'b0, 1'b1, pk(2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000));
        step("lw_sticky",  7'b0000011, 3'b000, 1'b0, 1'b0, pk(2'b01, 0, 0, 1, 1, 0, 2'b00, 3'b000));
        step("jal_sticky", 7'b1101111, 3'b000, 1'b0, 1'b0, pk(2'b10, 0, 1, 0, 1, 1, 2'b11, 3'b000));
        @(posedge clk);
        #1;
        check_flag("flag_sticky", 1'b1);

        // Asynchronous clear between clock edges
        #2;
        reset = 1'b1;
        #1;
        check_flag("async_clear", 1'b0);

        // Reset held over an edge with an illegal op present keeps the flag clear
        bus.op = 7'b0000000;
        @(posedge clk);
        #1;
        check_flag("reset_wins", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step("zero_op",    7'b0000000, 3'b000, 1'b0, 1'b1, pk(2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000));
        @(posedge clk);
        #1;
        check_flag("flag_relearn", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
